// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider_pkg
// Purpose  : Shared definitions for the sequential restoring divider:
//            control-state encoding, default operand width and the
//            iteration-counter width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seq_restoring_divider_pkg;

  // Default operand / quotient / remainder width.
  localparam int C_DEFAULT_W = 4;

  // Control states of the divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Width of a counter that must hold the value w (iterations remaining).
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_trial_subtract.sv
`default_nettype none
// ============================================================================
// Module   : div_trial_subtract
// Purpose  : Combinational (W+1)-bit trial subtractor for one restoring
//            division step. Returns minuend - subtrahend and a flag that is
//            set when the result is non-negative.
// Ports    : minuend      in  W+1  shifted partial remainder
//            subtrahend   in  W+1  zero-extended divisor
//            difference   out W+1  minuend - subtrahend (two's complement)
//            non_negative out 1    difference did not go below zero
// Revision : 1.0 - initial release
// ============================================================================
module div_trial_subtract
  import seq_restoring_divider_pkg::*;
#(
  parameter int W = C_DEFAULT_W
) (
  input  logic [W:0] minuend,
  input  logic [W:0] subtrahend,
  output logic [W:0] difference,
  output logic       non_negative
);

  assign difference = minuend - subtrahend;

  // The restoring invariant keeps the partial remainder below the divisor
  // before each shift, so the shifted value is below 2*D. The true
  // difference therefore lies in (-2^W, 2^W) and its MSB alone is the sign.
  assign non_negative = ~difference[W];

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider
// Purpose  : Unsigned sequential restoring divider. Produces one quotient
//            bit per clock by shift and trial subtraction, with valid/ready
//            handshakes on operand and result sides. A zero divisor
//            short-cuts to a flagged result (quotient all ones,
//            remainder = dividend).
// Ports    : clk          in  1  rising-edge clock
//            rst_n        in  1  asynchronous active-low reset
//            in_valid     in  1  operand pair offered
//            in_ready     out 1  divider idle and able to accept
//            dividend     in  W  unsigned dividend
//            divisor      in  W  unsigned divisor
//            out_valid    out 1  result available
//            out_ready    in  1  consumer takes result
//            quotient     out W  unsigned quotient
//            remainder    out W  unsigned remainder
//            div_by_zero  out 1  result came from a zero divisor
// Revision : 1.0 - initial release
// ============================================================================
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int W = C_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = count_width(W);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  div_state_t    r_state;
  div_state_t    w_state_next;

  logic [W:0]    r_p;        // partial remainder
  logic [W-1:0]  r_aq;       // dividend shifting out / quotient shifting in
  logic [W-1:0]  r_d;        // captured divisor
  logic [CW-1:0] r_count;    // iterations remaining

  logic [W-1:0]  r_quotient;
  logic [W-1:0]  r_remainder;
  logic          r_dbz;

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  logic          w_divisor_zero;
  logic          w_last_iter;
  logic [2*W:0]  w_pa_shift;
  logic [W:0]    w_shift_p;
  logic [W:0]    w_diff;
  logic          w_non_neg;
  logic [W:0]    w_p_next;
  logic [W-1:0]  w_aq_next;

  assign w_divisor_zero = (divisor == '0);
  assign w_last_iter    = (r_count == CW'(1));

  // {P,Aq} shifted left by one; the upper W+1 bits form the trial minuend.
  assign w_pa_shift = {r_p, r_aq} << 1;
  assign w_shift_p  = w_pa_shift[2*W:W];

  div_trial_subtract #(
    .W (W)
  ) u_trial_subtract (
    .minuend      (w_shift_p),
    .subtrahend   ({1'b0, r_d}),
    .difference   (w_diff),
    .non_negative (w_non_neg)
  );

  // Restore (keep the shifted value) when the trial went negative.
  assign w_p_next  = w_non_neg ? w_diff : w_shift_p;
  // The freed LSB of Aq receives the new quotient bit.
  assign w_aq_next = w_pa_shift[W-1:0] | {{(W-1){1'b0}}, w_non_neg};

  // --------------------------------------------------------------------------
  // Control FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and state-decoded handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last_iter) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Returning to IDLE here (rather than accepting directly from DONE)
        // keeps the output handshake and the next accept on separate edges.
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p         <= '0;
      r_aq        <= '0;
      r_d         <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_divisor_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_d     <= divisor;
              r_aq    <= dividend;
              r_p     <= '0;
              r_count <= CW'(W);
            end
          end
        end
        RUN: begin
          r_p     <= w_p_next;
          r_aq    <= w_aq_next;
          r_count <= r_count - CW'(1);
          if (w_last_iter) begin
            r_quotient  <= w_aq_next;
            r_remainder <= w_p_next[W-1:0];
            r_dbz       <= 1'b0;
          end
        end
        DONE: begin
          // Results held until the consumer takes them.
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_restoring_divider
// Purpose  : Self-checking bench for seq_restoring_divider (W=4). Stimulus
//            pushes expected results into a scoreboard queue; a monitor
//            compares them whenever the divider presents a result.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_restoring_divider #(
    .W (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: compare every presented result against the scoreboard head;
  // the entry is retired only when the consumer takes it, so a held result
  // is re-checked (stability) on every cycle it is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got q=%0d r=%0d dbz=%0d expected none",
                 quotient, remainder, div_by_zero);
      end else begin
        chk("quotient", quotient, sb[0].q);
        chk("remainder", remainder, sb[0].r);
        chk("div_by_zero", div_by_zero, sb[0].dbz);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Issue one operand pair and wait until the result is presented.
  // Latency n counts edges after the accept edge until out_valid is seen.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_issue", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    e.q = eq; e.r = er; e.dbz = edbz;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = ~a;     // must not disturb the operation in flight
    divisor  = ~b;
    n = 0;
    while (!out_valid && n < 100) begin
      chk("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, (b == '0) ? 0 : W);
  endtask

  // Wait for the output handshake and confirm the return to IDLE.
  task automatic drain();
    int n;
    n = 0;
    while (out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 13 / 3 = 4 rem 1
    run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    drain();

    // 15 / 1 = 15 rem 0, then 2 / 9 = 0 rem 2
    run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    drain();
    run_div(4'd2, 4'd9, 4'd0, 4'd2, 1'b0);
    drain();

    // 7 / 0 : flagged result in the cycle after accept
    run_div(4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    drain();

    // 10 / 4 = 2 rem 2 with consumer stalled 5 cycles
    out_ready = 1'b0;
    run_div(4'd10, 4'd4, 4'd2, 4'd2, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_in_ready", in_ready, 1);
    chk("stall_release_out_valid", out_valid, 0);

    // Busy with in_valid held and operands changing, then reset mid-RUN
    in_valid = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd5;
    @(posedge clk); #1;
    dividend = 4'd3;
    divisor  = 4'd1;
    chk("busy_in_ready_1", in_ready, 0);
    @(posedge clk); #1;
    dividend = 4'd12;
    divisor  = 4'd0;
    chk("busy_in_ready_2", in_ready, 0);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrun_rst_in_ready", in_ready, 1);
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_quotient", quotient, 0);
    chk("midrun_rst_remainder", remainder, 0);
    chk("midrun_rst_dbz", div_by_zero, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_div(4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
    drain();

    // All operand pairs
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        eq = (b == 0) ? 4'd15 : W'(a / b);
        er = (b == 0) ? W'(a) : W'(a % b);
        run_div(W'(a), W'(b), eq, er, (b == 0));
        if (b != 0) begin
          chk("identity", 32'(quotient) * 32'(b) + 32'(remainder), a);
          chk("rem_lt_div", (32'(remainder) < b) ? 1 : 0, 1);
        end
        drain();
      end
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

- Unsigned sequential restoring divider: one quotient bit per clock by shift and trial subtraction.
- Serves as the division companion to the team's combinational add/subtract datapath, inverting multiplication-by-repeated-addition.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.

## Interface
- `W`, default 4: operand, quotient and remainder width, ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  divider idle and able to accept.
- `dividend`  in  W  unsigned dividend.
- `divisor`  in  W  unsigned divisor.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `quotient`  out  W  unsigned quotient.
- `remainder`  out  W  unsigned remainder.
- `div_by_zero`  out  1  result came from a zero divisor.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid` with nonzero `divisor`:
    - capture divisor into D;
    - load Aq=dividend and P=0 (P is W+1 bits);
    - load count=W;
    - go to RUN.
  - On `in_valid` with zero `divisor`:
    - load quotient=all ones, remainder=dividend, `div_by_zero`=1;
    - go to DONE.
- RUN, each cycle:
  - shift {P,Aq} left 1;
  - trial = P − {0,D}, computed at W+1 bits;
  - if the trial MSB is 0: P=trial and Aq[0]=1; else P is unchanged and Aq[0]=0;
  - count decrements.
  - On the cycle count reaches 0: quotient=Aq, remainder=P[W-1:0], `div_by_zero`=0; go to DONE.
- DONE
  - `out_valid`=1.
  - `quotient`, `remainder` and `div_by_zero` are held stable while `out_ready`=0.
  - On `out_ready`=1, go to IDLE. Result registers keep their values until the next load.
- Input handling:
  - `in_valid` is ignored outside IDLE because `in_ready`=0 there.
  - Operands are sampled only at the accept edge, so later input changes have no effect.
- Arithmetic: unsigned only. Remainder < divisor always holds. quotient·divisor + remainder = dividend.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`=1, `out_valid`=0;
  - `quotient`=0, `remainder`=0, `div_by_zero`=0;
  - internal P, Aq, D and count all 0.
- Latency, nonzero divisor: accept at edge E0; RUN iterations at edges E1..EW; `out_valid` goes high after EW. That is W cycles from accept to result, 4 at the default.
- Latency, zero divisor: `out_valid` goes high in the cycle right after the accept edge.
- Throughput: back-to-back issue needs one IDLE cycle after the output handshake.
  - The output handshake and a new accept never share an edge.
  - Minimum spacing between accepts is W+2 cycles.
- Reset asserted mid-RUN or mid-DONE returns everything immediately to reset values. The in-flight result is discarded.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the state typedef (IDLE, RUN, DONE);
  - the default width constant;
  - a counter-width function, clog2(W+1).
- One sub-module: `div_trial_subtract`, a combinational (W+1)-bit subtractor returning difference and a non-negative flag. The control FSM and registers stay in the top.

## Test plan
- 13 ÷ 3, out_ready held 1 → `out_valid` 4 cycles after accept; quotient=4, remainder=1, dbz=0.
- 15 ÷ 1, then 2 ÷ 9 → 15 rem 0, then 0 rem 2; `in_ready`=0 throughout each RUN.
- 7 ÷ 0 → `out_valid` the cycle after accept; quotient=15, remainder=7, dbz=1.
- 10 ÷ 4 with out_ready held 0 for 5 cycles → quotient=2 and remainder=2 stay stable with `out_valid`=1; return to IDLE the cycle after out_ready=1.
- Hold `in_valid` with changing operands while busy; deassert rst_n mid-RUN → no extra accepts while busy; on reset, all outputs 0 and `in_ready`=1 at once; the next 9 ÷ 2 gives 4 rem 1.
- Random regression, all 256 operand pairs at W=4 → quotient·divisor + remainder = dividend and remainder < divisor for every nonzero divisor.
